// File: rtl/traffic_light_monitor_pkg.sv
// Shared definitions for the traffic light monitor: light encodings, phase
// codes, monitor state type and direction indices.
// Optional feature macro used by the monitor: TRAFFIC_MON_STATUS_EN.
package traffic_pkg;

  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b100;

  localparam int DIR_N = 0;
  localparam int DIR_S = 1;
  localparam int DIR_E = 2;
  localparam int DIR_W = 3;

  typedef enum logic [2:0] {
    PH_N_G = 3'd0,
    PH_N_Y = 3'd1,
    PH_S_G = 3'd2,
    PH_S_Y = 3'd3,
    PH_E_G = 3'd4,
    PH_E_Y = 3'd5,
    PH_W_G = 3'd6,
    PH_W_Y = 3'd7
  } phase_e;

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } mon_state_e;

  // Legal successor of a phase; W-Y wraps back to N-G.
  function automatic logic [2:0] next_phase(input logic [2:0] p);
    return p + 3'd1;
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Light buses in, monitor results out. The master side drives the lights
// (controller or bench), the slave side is the monitor.
// With TRAFFIC_MON_STATUS_EN defined, adds clr_status / err_status.
interface traffic_light_monitor_if #(
  parameter int ROUND_W = 8
);
  logic [2:0]         n_lights;
  logic [2:0]         s_lights;
  logic [2:0]         e_lights;
  logic [2:0]         w_lights;
  logic [2:0]         phase;
  logic               phase_valid;
  logic               locked;
  logic               err_pattern;
  logic               err_seq;
  logic               err_timing;
  logic [ROUND_W-1:0] rounds;
`ifdef TRAFFIC_MON_STATUS_EN
  logic               clr_status;
  logic [2:0]         err_status;
`endif

  modport master (
    output n_lights, s_lights, e_lights, w_lights,
`ifdef TRAFFIC_MON_STATUS_EN
    output clr_status,
    input  err_status,
`endif
    input  phase, phase_valid, locked, err_pattern, err_seq, err_timing, rounds
  );

  modport slave (
    input  n_lights, s_lights, e_lights, w_lights,
`ifdef TRAFFIC_MON_STATUS_EN
    input  clr_status,
    output err_status,
`endif
    output phase, phase_valid, locked, err_pattern, err_seq, err_timing, rounds
  );

endinterface

// File: rtl/traffic_light_monitor_decode.sv
// Purely combinational decode of the four light buses into {legal, phase}.
// Legal means every field is a valid one-hot light and exactly one is non-red.
module traffic_light_decode
  import traffic_pkg::*;
(
  input  logic [2:0] i_n_lights,
  input  logic [2:0] i_s_lights,
  input  logic [2:0] i_e_lights,
  input  logic [2:0] i_w_lights,
  output logic       o_legal,
  output logic [2:0] o_phase
);

  logic [2:0] w_field [4];
  logic [3:0] w_enc_ok;
  logic [3:0] w_non_red;
  logic [3:0] w_yellow;
  logic [1:0] w_dir;

  assign w_field[DIR_N] = i_n_lights;
  assign w_field[DIR_S] = i_s_lights;
  assign w_field[DIR_E] = i_e_lights;
  assign w_field[DIR_W] = i_w_lights;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_field
      assign w_enc_ok[gi]  = (w_field[gi] == LIGHT_GREEN) || (w_field[gi] == LIGHT_YELLOW) ||
                             (w_field[gi] == LIGHT_RED);
      assign w_non_red[gi] = (w_field[gi] != LIGHT_RED);
      assign w_yellow[gi]  = (w_field[gi] == LIGHT_YELLOW);
    end
  endgenerate

  // Pick the active direction and build phase = 2*dir + yellow.
  always_comb begin
    w_dir = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (w_non_red[i]) w_dir = 2'(i);
    end
    o_legal = (&w_enc_ok) && ($countones(w_non_red) == 1);
    o_phase = {w_dir, w_yellow[w_dir]};
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light monitor: samples the light buses, tracks the phase sequence
// and dwell times, and pulses one error per cycle (pattern > seq > timing).
// Optional sticky error status enabled by defining TRAFFIC_MON_STATUS_EN.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 4,
  parameter int DWELL_W       = 4,
  parameter int ROUND_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_a,
  traffic_light_monitor_if.slave  mon
);

  localparam logic [DWELL_W-1:0] GREEN_D  = DWELL_W'(GREEN_CYCLES);
  localparam logic [DWELL_W-1:0] YELLOW_D = DWELL_W'(YELLOW_CYCLES);

  mon_state_e         r_state, w_state_nx;
  logic [2:0]         r_phase, w_phase_nx;
  logic               r_phase_valid, w_valid_nx;
  logic [DWELL_W-1:0] r_dwell, w_dwell_nx;
  logic               r_overstay, w_over_nx;
  logic [ROUND_W-1:0] r_rounds, w_rounds_nx;
  logic               r_err_pattern, r_err_seq, r_err_timing;
  logic               w_ep, w_es, w_et;

  logic               w_legal;
  logic [2:0]         w_sample;
  logic [DWELL_W-1:0] w_expected;
  logic [DWELL_W-1:0] w_dwell_inc;

  traffic_light_decode u_decode (
    .i_n_lights (mon.n_lights),
    .i_s_lights (mon.s_lights),
    .i_e_lights (mon.e_lights),
    .i_w_lights (mon.w_lights),
    .o_legal    (w_legal),
    .o_phase    (w_sample)
  );

  assign w_expected  = r_phase[0] ? YELLOW_D : GREEN_D;
  assign w_dwell_inc = (r_dwell == '1) ? r_dwell : r_dwell + 1'b1;

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!rst_a) begin
      r_state       <= SYNC;
      r_phase       <= 3'd0;
      r_phase_valid <= 1'b0;
      r_dwell       <= '0;
      r_overstay    <= 1'b0;
      r_rounds      <= '0;
      r_err_pattern <= 1'b0;
      r_err_seq     <= 1'b0;
      r_err_timing  <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_phase       <= w_phase_nx;
      r_phase_valid <= w_valid_nx;
      r_dwell       <= w_dwell_nx;
      r_overstay    <= w_over_nx;
      r_rounds      <= w_rounds_nx;
      r_err_pattern <= w_ep;
      r_err_seq     <= w_es;
      r_err_timing  <= w_et;
    end
  end

  // Next-state logic: the first partial phase after SYNC is never timed.
  always_comb begin
    w_state_nx  = r_state;
    w_phase_nx  = r_phase;
    w_valid_nx  = r_phase_valid;
    w_dwell_nx  = r_dwell;
    w_over_nx   = r_overstay;
    w_rounds_nx = r_rounds;
    w_ep        = 1'b0;
    w_es        = 1'b0;
    w_et        = 1'b0;
    case (r_state)
      SYNC: begin
        if (!w_legal) begin
          w_ep       = 1'b1;
          w_valid_nx = 1'b0;
          w_dwell_nx = '0;
        end else if (r_phase_valid && (w_sample == next_phase(r_phase))) begin
          w_state_nx = TRACK;
          w_phase_nx = w_sample;
          w_dwell_nx = DWELL_W'(1);
          w_over_nx  = 1'b0;
        end else if (r_phase_valid && (w_sample == r_phase)) begin
          w_dwell_nx = w_dwell_inc;
        end else begin
          w_phase_nx = w_sample;
          w_valid_nx = 1'b1;
          w_dwell_nx = DWELL_W'(1);
        end
      end
      TRACK: begin
        if (!w_legal) begin
          w_ep       = 1'b1;
          w_state_nx = SYNC;
          w_valid_nx = 1'b0;
          w_dwell_nx = '0;
          w_over_nx  = 1'b0;
        end else if (w_sample == r_phase) begin
          w_dwell_nx = w_dwell_inc;
          if ((r_dwell >= w_expected) && !r_overstay) begin
            w_et      = 1'b1;
            w_over_nx = 1'b1;
          end
        end else if (w_sample == next_phase(r_phase)) begin
          w_et       = (r_dwell < w_expected);
          w_phase_nx = w_sample;
          w_dwell_nx = DWELL_W'(1);
          w_over_nx  = 1'b0;
          if (r_phase == PH_W_Y) w_rounds_nx = r_rounds + 1'b1;
        end else begin
          w_es       = 1'b1;
          w_state_nx = SYNC;
          w_phase_nx = w_sample;
          w_valid_nx = 1'b1;
          w_dwell_nx = DWELL_W'(1);
          w_over_nx  = 1'b0;
        end
      end
      default: begin
        w_state_nx = SYNC;
      end
    endcase
  end

  assign mon.phase       = r_phase;
  assign mon.phase_valid = r_phase_valid;
  assign mon.locked      = (r_state == TRACK);
  assign mon.err_pattern = r_err_pattern;
  assign mon.err_seq     = r_err_seq;
  assign mon.err_timing  = r_err_timing;
  assign mon.rounds      = r_rounds;

`ifdef TRAFFIC_MON_STATUS_EN
  logic [2:0] r_err_status;

  // Sticky error summary; a new error beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_a) begin
      r_err_status <= 3'b000;
    end else begin
      r_err_status <= (mon.clr_status ? 3'b000 : r_err_status) | {w_et, w_es, w_ep};
    end
  end

  assign mon.err_status = r_err_status;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: a behavioural light generator
// followed by timing, sequence, pattern and reset scenarios. Expected results
// are queued as each sample is driven and compared one edge later.
module tb_traffic_light_monitor;

  typedef struct packed {
    logic [2:0] phase;
    logic       ph_chk;
    logic       valid;
    logic       locked;
    logic       ep;
    logic       es;
    logic       et;
    logic [7:0] rounds;
  } exp_t;

  logic clk;
  logic rst_a;
  int   errors;
  int   checks;
  exp_t sb_q[$];

  traffic_light_monitor_if #(.ROUND_W(8)) mon_if ();

  traffic_light_monitor #(
    .GREEN_CYCLES  (8),
    .YELLOW_CYCLES (4),
    .DWELL_W       (4),
    .ROUND_W       (8)
  ) dut (
    .clk   (clk),
    .rst_a (rst_a),
    .mon   (mon_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] lights_of(input logic [2:0] p);
    logic [2:0] f [4];
    for (int i = 0; i < 4; i++) f[i] = 3'b100;
    f[p[2:1]] = p[0] ? 3'b010 : 3'b001;
    return {f[0], f[1], f[2], f[3]};
  endfunction

  function automatic exp_t mk(input logic [2:0] ph, input logic v, input logic lk,
                              input logic ep, input logic es, input logic et,
                              input logic [7:0] rnd);
    exp_t e;
    e.phase = ph; e.ph_chk = v; e.valid = v; e.locked = lk;
    e.ep = ep; e.es = es; e.et = et; e.rounds = rnd;
    return e;
  endfunction

  function automatic exp_t mk_reset();
    exp_t e;
    e = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    e.ph_chk = 1'b1;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_queue: got 0 entries expected 1", tag);
      return;
    end
    e = sb_q.pop_front();
    if (e.ph_chk) chk({tag, "_phase"}, 32'(mon_if.phase), 32'(e.phase));
    chk({tag, "_valid"},  32'(mon_if.phase_valid), 32'(e.valid));
    chk({tag, "_locked"}, 32'(mon_if.locked),      32'(e.locked));
    chk({tag, "_errpat"}, 32'(mon_if.err_pattern), 32'(e.ep));
    chk({tag, "_errseq"}, 32'(mon_if.err_seq),     32'(e.es));
    chk({tag, "_errtim"}, 32'(mon_if.err_timing),  32'(e.et));
    chk({tag, "_rounds"}, 32'(mon_if.rounds),      32'(e.rounds));
    $display("txn %s: lights=%03b_%03b_%03b_%03b phase=%0d valid=%0b locked=%0b err=%0b%0b%0b rounds=%0d",
             tag, mon_if.n_lights, mon_if.s_lights, mon_if.e_lights, mon_if.w_lights,
             mon_if.phase, mon_if.phase_valid, mon_if.locked, mon_if.err_pattern,
             mon_if.err_seq, mon_if.err_timing, mon_if.rounds);
  endtask

  // Drive one sample, queue its expected result, compare after the edge.
  task automatic one(input string tag, input logic [11:0] lights, input exp_t e);
    {mon_if.n_lights, mon_if.s_lights, mon_if.e_lights, mon_if.w_lights} = lights;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  // n error-free samples of phase p with fixed lock state and round count.
  task automatic seg(input string tag, input logic [2:0] p, input int n,
                     input logic lk, input logic [7:0] rnd);
    for (int i = 0; i < n; i++)
      one(tag, lights_of(p), mk(p, 1'b1, lk, 1'b0, 1'b0, 1'b0, rnd));
  endtask

  initial begin
    int r, dir, off;
    logic [2:0] p;
    errors = 0;
    checks = 0;
    rst_a  = 1'b0;
    {mon_if.n_lights, mon_if.s_lights, mon_if.e_lights, mon_if.w_lights} = lights_of(3'd0);
`ifdef TRAFFIC_MON_STATUS_EN
    mon_if.clr_status = 1'b0;
`endif

    // Reset held for two edges.
    one("reset0", lights_of(3'd0), mk_reset());
    one("reset1", lights_of(3'd0), mk_reset());
    rst_a = 1'b1;

    // Correct controller for four full rounds: lock on first N-G -> N-Y.
    for (int t = 0; t < 192; t++) begin
      r   = t % 48;
      dir = r / 12;
      off = r % 12;
      p   = 3'(2 * dir + ((off >= 8) ? 1 : 0));
      one("gen", lights_of(p), mk(p, 1'b1, (t >= 8), 1'b0, 1'b0, 1'b0, 8'(t / 48)));
    end

    // N green held 9 samples: overstay flagged once on the 9th.
    seg("ng_long", 3'd0, 8, 1'b1, 8'd4);
    one("ng_over", lights_of(3'd0), mk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd4));
    seg("ny_after", 3'd1, 4, 1'b1, 8'd4);
    seg("sg", 3'd2, 8, 1'b1, 8'd4);

    // S yellow cut short: timing error on the E-G sample.
    seg("sy_short", 3'd3, 3, 1'b1, 8'd4);
    one("eg_short", lights_of(3'd4), mk(3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd4));
    seg("eg", 3'd4, 7, 1'b1, 8'd4);
    seg("ey", 3'd5, 4, 1'b1, 8'd4);
    seg("wg", 3'd6, 8, 1'b1, 8'd4);
    seg("wy", 3'd7, 4, 1'b1, 8'd4);
    seg("ng5", 3'd0, 8, 1'b1, 8'd5);
    seg("ny5", 3'd1, 1, 1'b1, 8'd5);

    // Skip from N-Y to E-G: sequence error, drop lock, relock on E-Y.
    one("seq_jump", lights_of(3'd4), mk(3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5));
    seg("eg_sync", 3'd4, 7, 1'b0, 8'd5);
    seg("ey_relock", 3'd5, 4, 1'b1, 8'd5);
    seg("wg_pre", 3'd6, 3, 1'b1, 8'd5);

    // Illegal patterns: two greens, then a malformed field.
    one("pat_two", 12'b001_001_100_100, mk(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5));
    one("pat_bad", 12'b011_100_100_100, mk(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5));
`ifdef TRAFFIC_MON_STATUS_EN
    chk("status_sticky", 32'(mon_if.err_status), 32'(3'b111));
    mon_if.clr_status = 1'b1;
`endif
    seg("ey_cand", 3'd5, 1, 1'b0, 8'd5);
`ifdef TRAFFIC_MON_STATUS_EN
    mon_if.clr_status = 1'b0;
    chk("status_clr", 32'(mon_if.err_status), 32'(3'b000));
`endif
    seg("ey_cand", 3'd5, 3, 1'b0, 8'd5);
    seg("wg_lock", 3'd6, 4, 1'b1, 8'd5);

    // Reset mid W-G while locked with rounds=5.
    rst_a = 1'b0;
    one("reset_mid", lights_of(3'd6), mk_reset());
`ifdef TRAFFIC_MON_STATUS_EN
    chk("status_reset", 32'(mon_if.err_status), 32'(3'b000));
`endif
    rst_a = 1'b1;
    one("post_reset", lights_of(3'd6), mk(3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
